// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage latches: stage state encoding,
// default ID/EX payload widths and the ID/EX field map.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int unsigned ID_EX_DATA_W = 116;
    localparam int unsigned ID_EX_CTRL_W = 16;
    localparam int unsigned STATS_CNT_W  = 32;

    // ID/EX datapath payload, LSB first.
    localparam int unsigned SA_LSB        = 0;
    localparam int unsigned SA_W          = 5;
    localparam int unsigned RD_LSB        = SA_LSB + SA_W;
    localparam int unsigned RD_W          = 5;
    localparam int unsigned RT_LSB        = RD_LSB + RD_W;
    localparam int unsigned RT_W          = 5;
    localparam int unsigned RS_LSB        = RT_LSB + RT_W;
    localparam int unsigned RS_W          = 5;
    localparam int unsigned READDATA2_LSB = RS_LSB + RS_W;
    localparam int unsigned READDATA2_W   = 32;
    localparam int unsigned READDATA1_LSB = READDATA2_LSB + READDATA2_W;
    localparam int unsigned READDATA1_W   = 32;
    localparam int unsigned SIGEXT_LSB    = READDATA1_LSB + READDATA1_W;
    localparam int unsigned SIGEXT_W      = 32;

    // ID/EX control payload, LSB first.
    localparam int unsigned ALUOP_LSB        = 0;
    localparam int unsigned ALUOP_W          = 4;
    localparam int unsigned ALUSRC_BIT       = 4;
    localparam int unsigned ALUSHIFTIMM_BIT  = 5;
    localparam int unsigned REGDST_LSB       = 6;
    localparam int unsigned REGDST_W         = 2;
    localparam int unsigned LOADIMM_BIT      = 8;
    localparam int unsigned MEMWRITE_LSB     = 9;
    localparam int unsigned MEMWRITE_W       = 2;
    localparam int unsigned MEMTOREG_BIT     = 11;
    localparam int unsigned MEMREADWIDTH_LSB = 12;
    localparam int unsigned MEMREADWIDTH_W   = 3;
    localparam int unsigned REGWRITE_BIT     = 15;

    // True when an ID/EX control word would update architectural state.
    function automatic logic id_ex_ctrl_writes(input logic [ID_EX_CTRL_W-1:0] ctrl);
        return ctrl[REGWRITE_BIT] | (|ctrl[MEMWRITE_LSB +: MEMWRITE_W]);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter used for the pipeline stage statistics.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage latch with a 2-entry skid buffer, flush and bubble masking.
// Optional stall/bubble statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = ID_EX_DATA_W,
    parameter int unsigned CTRL_W   = ID_EX_CTRL_W,
    parameter bit          CLR_DATA = 1'b1
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int unsigned CNT_W    = STATS_CNT_W
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              syncClr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_d;
    logic              in_ready_q;
    logic              in_ready_d;

    logic              valid_w;
    logic              accept;
    logic              emit;

    assign valid_w = (state_q != EMPTY);
    assign accept  = in_valid & in_ready_q;
    assign emit    = valid_w & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (syncClr) begin
            // Flush wins: the skid is abandoned and any same-cycle accept is dropped.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (accept) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = FULL;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Registered copy of the next state's readiness keeps out_ready off the in_ready path.
        in_ready_d = (state_d != FULL);
    end

    // NOTE: the payload registers are deliberately reset so a bubble after reset carries zeros, not stale data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = valid_w;
    assign out_ctrl  = valid_w ? main_ctrl_q : '0;
    assign out_data  = (CLR_DATA && !valid_w) ? '0 : main_data_q;

`ifdef PIPE_STAGE_STATS_EN
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (in_valid & ~in_ready_q & ~syncClr),
        .count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (out_ready & ~valid_w),
        .count (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, directed corner sequences and
// a scoreboard on every downstream transfer. Statistics checks build with PIPE_STAGE_STATS_EN.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int unsigned DW = ID_EX_DATA_W;
    localparam int unsigned CW = ID_EX_CTRL_W;

    logic          clock = 1'b0;
    logic          reset;
    logic          syncClr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          h_in_ready, h_out_valid;
    logic [DW-1:0] h_out_data;
    logic [CW-1:0] h_out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]   stall_cnt, bubble_cnt;
    logic [3:0]    h_stall_cnt, h_bubble_cnt;
`endif

    always #5 clock = ~clock;

    pipe_stage_skid #(
        .DATA_W   (DW),
        .CTRL_W   (CW),
        .CLR_DATA (1'b1)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .CNT_W    (32)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .syncClr   (syncClr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    pipe_stage_skid #(
        .DATA_W   (DW),
        .CTRL_W   (CW),
        .CLR_DATA (1'b0)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .CNT_W    (4)
`endif
    ) dut_hold (
        .clock     (clock),
        .reset     (reset),
        .syncClr   (syncClr),
        .in_valid  (in_valid),
        .in_ready  (h_in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (h_out_valid),
        .out_ready (out_ready),
        .out_data  (h_out_data),
        .out_ctrl  (h_out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt  (h_stall_cnt),
        .bubble_cnt (h_bubble_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [CW-1:0] c);
        return {c, 68'h0, c, ~c};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic clr, input logic [CW-1:0] c);
        in_valid  = iv;
        out_ready = ordy;
        syncClr   = clr;
        in_ctrl   = c;
        in_data   = data_of(c);
    endtask

    // Scoreboard: accepted payloads queue up, every downstream transfer pops one.
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;
    item_t sb_q[$];

    always @(negedge clock) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_expected_item", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) begin
                    item_t it;
                    it = sb_q.pop_front();
                    check("sb_out_ctrl", 128'(out_ctrl), 128'(it.c));
                    check("sb_out_data", 128'(out_data), 128'(it.d));
                    check("sb_hold_out_ctrl", 128'(h_out_ctrl), 128'(it.c));
                end
            end
            if (syncClr) sb_q.delete();
            if (in_valid && in_ready && !syncClr) sb_q.push_back('{c: in_ctrl, d: in_data});
        end
    end

    typedef struct {
        logic          iv;
        logic          ordy;
        logic          clr;
        logic [CW-1:0] c;
        logic          exp_ir;
        logic          exp_ov;
        logic [CW-1:0] exp_oc;
    } vec_t;
    vec_t vecs[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h0001};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 16'h0002};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b1, 16'h0002};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b1, 16'h0002};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b1, 16'h0005};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b1, 16'h0005};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 16'h0000};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0008, 1'b1, 1'b1, 16'h0008};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        step();
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_ctrl", 128'(out_ctrl), 128'(0));
        check("reset_out_data", 128'(out_data), 128'(0));
        check("reset_hold_out_data", 128'(h_out_data), 128'(0));
        reset = 1'b0;

        // Vector table: single-cycle transitions including flush in every state.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].clr, vecs[i].c);
            step();
            check($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].exp_ir));
            check($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].exp_ov));
            check($sformatf("vec%0d_out_ctrl", i), 128'(out_ctrl), 128'(vecs[i].exp_oc));
            check($sformatf("vec%0d_out_data", i), 128'(out_data),
                  vecs[i].exp_ov ? 128'(data_of(vecs[i].exp_oc)) : 128'(0));
        end

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, CW'(i));
            step();
            check($sformatf("stream%0d_in_ready", i), 128'(in_ready), 128'(1));
            check($sformatf("stream%0d_out_ctrl", i), 128'(out_ctrl), 128'(i));
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        step();
        check("stream_drained", 128'(out_valid), 128'(0));

        // Backpressure into the skid, then release.
        drive(1'b1, 1'b0, 1'b0, 16'hA001);
        step();
        check("bp_first_in_ready", 128'(in_ready), 128'(1));
        drive(1'b1, 1'b0, 1'b0, 16'hA002);
        step();
        check("bp_full_in_ready", 128'(in_ready), 128'(0));
        drive(1'b1, 1'b0, 1'b0, 16'hA003);
        step();
        check("bp_hold_in_ready", 128'(in_ready), 128'(0));
        check("bp_hold_out_ctrl", 128'(out_ctrl), 128'(16'hA001));
        drive(1'b1, 1'b1, 1'b0, 16'hA003);
        step();
        check("bp_rel1_out_ctrl", 128'(out_ctrl), 128'(16'hA002));
        check("bp_rel1_in_ready", 128'(in_ready), 128'(1));
        step();
        check("bp_rel2_out_ctrl", 128'(out_ctrl), 128'(16'hA003));
        drive(1'b0, 1'b1, 1'b0, '0);
        step();
        check("bp_drained", 128'(out_valid), 128'(0));

        // Data hold with CLR_DATA=0 once the stage empties.
        drive(1'b1, 1'b1, 1'b0, 16'h0042);
        in_data = 116'h1234;
        step();
        drive(1'b0, 1'b1, 1'b0, '0);
        step();
        check("hold_out_valid", 128'(h_out_valid), 128'(0));
        check("hold_out_ctrl", 128'(h_out_ctrl), 128'(0));
        check("hold_out_data", 128'(h_out_data), 128'(116'h1234));
        check("clr_out_data", 128'(out_data), 128'(0));

        // Flush while FULL with a payload offered.
        drive(1'b1, 1'b0, 1'b0, 16'hF001);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'hF002);
        step();
        drive(1'b1, 1'b0, 1'b1, 16'hFFFF);
        step();
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_out_ctrl", 128'(out_ctrl), 128'(0));
        check("flush_in_ready", 128'(in_ready), 128'(1));
        drive(1'b0, 1'b1, 1'b0, '0);
        step();
        check("flush_stays_empty", 128'(out_valid), 128'(0));

        // Reset mid-stream with A and B held.
        drive(1'b1, 1'b0, 1'b0, 16'hB001);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'hB002);
        step();
        check("rst_mid_full", 128'(in_ready), 128'(0));
        drive(1'b0, 1'b1, 1'b0, '0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check("rst_mid_out_ctrl", 128'(out_ctrl), 128'(0));
        check("rst_mid_out_data", 128'(out_data), 128'(0));
        check("rst_mid_in_ready", 128'(in_ready), 128'(1));
        step();
        step();
        check("rst_mid_no_emit", 128'(out_valid), 128'(0));

`ifdef PIPE_STAGE_STATS_EN
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'hC001);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'hC002);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'hC003);
        for (int i = 0; i < 5; i++) step();
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) step();
        check("stats_stall", 128'(stall_cnt), 128'(5));
        check("stats_bubble", 128'(bubble_cnt), 128'(3));
        check("stats_hold_stall", 128'(h_stall_cnt), 128'(5));
        check("stats_hold_bubble", 128'(h_bubble_cnt), 128'(3));
        drive(1'b1, 1'b0, 1'b0, 16'hC004);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'hC005);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'hC006);
        for (int i = 0; i < 20; i++) step();
        check("stats_stall_25", 128'(stall_cnt), 128'(25));
        check("stats_hold_stall_sat", 128'(h_stall_cnt), 128'(15));
        check("stats_bubble_kept", 128'(bubble_cnt), 128'(3));
`endif

        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) step();
        check("sb_empty_at_end", 128'(sb_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
